top_chip_conv: RTL and testbench
================================

// Module: top_chip_conv
// PURPOSE
// - Sequential single-MAC 2-D convolution engine: one output pixel/channel at a time, one MAC per accepted operand pair.
// - Operand streams: activations on a_*, weights on b_*. Results are emitted tagged with x/y/channel.
// - Sits between the testbench stream drivers and an external pseudo-2-port memory (1-cycle read latency) on ext_mem_*.
// PARAMETERS
// - IO_DATA_WIDTH 16: operand and output width (signed).
// - ACCUMULATION_WIDTH 32: accumulator width (signed).
// - EXT_MEM_HEIGHT 1<<20: external memory words.
// - EXT_MEM_WIDTH ACCUMULATION_WIDTH: external memory word width.
// - FEATURE_MAP_WIDTH 1024, FEATURE_MAP_HEIGHT 1024: output map size (same as input, "same" padding).
// - INPUT_NB_CHANNELS 64, OUTPUT_NB_CHANNELS 64: channel counts.
// - KERNEL_SIZE 3: odd square kernel size.
// PORTS
// - clk  in 1: single clock, all logic on rising edge.
// - rst_in  in 1: synchronous, active-high reset.
// - ext_mem_read_addr  out clog2(EXT_MEM_HEIGHT): unused, held 0.
// - ext_mem_qout  in EXT_MEM_WIDTH: ignored.
// - ext_mem_write_addr  out clog2(EXT_MEM_HEIGHT): write address.
// - ext_mem_din  out EXT_MEM_WIDTH: write data.
// - ext_mem_write_en  out 1: write strobe.
// - a_input  in IO_DATA_WIDTH: activation, signed.
// - a_valid  in 1: activation valid.
// - a_ready  out 1: activation accepted.
// - b_input  in IO_DATA_WIDTH: weight, signed.
// - b_valid  in 1: weight valid.
// - b_ready  out 1: weight accepted.
// - out  out IO_DATA_WIDTH: signed result.
// - output_valid  out 1: 1-cycle result strobe.
// - output_x / output_y / output_ch  out clog2(W) / clog2(H) / clog2(OC): result coordinates.
// - start  in 1: start pulse.
// - running  out 1: busy flag.
// BEHAVIOUR
// - Reset: all outputs 0, FSM IDLE, accumulator and counters 0. Reset mid-run aborts immediately; no output is emitted.
// - FSM: IDLE -(start)-> FETCH -(last tap accepted)-> EMIT -> FETCH (next output) or IDLE (after last output). start is ignored unless in IDLE.
// - running = 1 in FETCH/EMIT; rises the cycle after start is sampled; falls the cycle after the final EMIT.
// - Output order: y outer, x, co inner. Tap order per output: ky outer, kx, ci inner. Input coordinate = (x+kx-K/2, y+ky-K/2).
// - Out-of-bounds taps (zero padding) are skipped with no handshake and no cycle cost. The bench does not send them.
// - Joint handshake: a_ready = b_ready = FETCH && a_valid && b_valid. Both streams transfer together.
// - One valid-low cycle stalls FETCH without losing state.
// - MAC: acc <= acc + sext(a*b), ACCUMULATION_WIDTH bits, two's-complement wrap. acc clears at the start of each output.
// - EMIT (1 cycle, registered outputs):
//   - output_valid=1 with out = acc saturated to signed IO_DATA_WIDTH range, plus coordinates.
//   - Latency: 1 cycle after the last tap handshake.
//   - out/coords hold their values while output_valid=0.
// CONFIGURATION
// - OUT_WRITEBACK_EN defined:
//   - In EMIT, ext_mem_write_en=1, ext_mem_write_addr = co + OC*(x + W*y), ext_mem_din = full unsaturated acc.
// - Macro undefined: ext_mem_write_en, write_addr and din are constantly 0.
// STRUCTURE
// - Package top_chip_conv_pkg:
//   - state_t enum {IDLE, FETCH, EMIT}.
//   - Saturation function sat16.
//   - Address-width localparams.
// - Sub-module conv_mac:
//   - Ports: clk, rst_in, clear, en, a, b.
//   - Output: acc register.
// - External memory is instantiated outside this block.
// TESTING
// - W=H=1, K=1, IC=OC=1: start; a=3, b=-2 -> one output_valid, out=-6, x=y=ch=0, running falls next cycle.
// - Same config: a=32767, b=32767 -> out=32767 (saturated). With OUT_WRITEBACK_EN: din=1073676289, addr 0.
// - W=H=2, K=3, IC=OC=1, all a=1, b=1:
//   - Exactly 16 handshakes total.
//   - Outputs (0,0), (1,0), (0,1), (1,1) each = 4.
// - Backpressure: drop a_valid for 5 cycles mid-output -> a_ready/b_ready low, result unchanged.
// - Reset asserted during FETCH -> next cycle running=0, output_valid=0; a new start yields a correct full run.
// - start pulsed while running -> ignored; output count unchanged.

Source files
------------

// File: rtl/top_chip_conv_pkg.sv
// Shared types and helpers for the top_chip_conv convolution engine.
//   state_t           : FSM encoding (IDLE, FETCH, EMIT)
//   IO_DATA_WIDTH     : signed operand/result width
//   ACCUMULATION_WIDTH: signed accumulator width
//   cw()              : index width helper, never below 1 bit
//   sat16()           : saturate an accumulator value to the signed IO range
package top_chip_conv_pkg;

   localparam int unsigned IO_DATA_WIDTH      = 16;
   localparam int unsigned ACCUMULATION_WIDTH = 32;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      EMIT  = 2'd2
   } state_t;

   // Width of an index into n entries; a 1-entry range still gets one bit.
   function automatic int unsigned cw(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // In range when every bit above the IO sign bit matches the sign.
   function automatic logic signed [IO_DATA_WIDTH-1:0] sat16(
      input logic signed [ACCUMULATION_WIDTH-1:0] v
   );
      logic [ACCUMULATION_WIDTH-IO_DATA_WIDTH:0] upper;
      upper = v[ACCUMULATION_WIDTH-1:IO_DATA_WIDTH-1];
      if ((upper == '0) || (upper == '1)) begin
         return v[IO_DATA_WIDTH-1:0];
      end else if (v[ACCUMULATION_WIDTH-1]) begin
         return {1'b1, {(IO_DATA_WIDTH-1){1'b0}}};
      end else begin
         return {1'b0, {(IO_DATA_WIDTH-1){1'b1}}};
      end
   endfunction

endpackage

// File: rtl/top_chip_conv_mac.sv
// Single multiply-accumulate unit for top_chip_conv.
//   clk, rst_in : clock, synchronous active-high reset
//   clear       : zero the accumulator (start of a new output)
//   en          : accumulate a*b this cycle
//   a, b        : signed operands
//   acc         : accumulator register
//   acc_nxt_c   : combinational next accumulator value
module conv_mac
   import top_chip_conv_pkg::*;
(
   input  logic                                 clk,
   input  logic                                 rst_in,
   input  logic                                 clear,
   input  logic                                 en,
   input  logic signed [IO_DATA_WIDTH-1:0]      a,
   input  logic signed [IO_DATA_WIDTH-1:0]      b,
   output logic signed [ACCUMULATION_WIDTH-1:0] acc,
   output logic signed [ACCUMULATION_WIDTH-1:0] acc_nxt_c
);

   logic signed [ACCUMULATION_WIDTH-1:0] acc_q;
   logic signed [ACCUMULATION_WIDTH-1:0] prod;

   // Sign-extended operands give the exact product modulo 2^ACC.
   assign prod = ACCUMULATION_WIDTH'(a) * ACCUMULATION_WIDTH'(b);

   // Next accumulator: clear wins, otherwise wrap-around add.
   always_comb begin
      acc_nxt_c = acc_q;
      if (clear) begin
         acc_nxt_c = '0;
      end else if (en) begin
         acc_nxt_c = acc_q + prod;
      end
   end

   always_ff @(posedge clk) begin
      if (rst_in) begin
         acc_q <= '0;
      end else begin
         acc_q <= acc_nxt_c;
      end
   end

   assign acc = acc_q;

endmodule

// File: rtl/top_chip_conv.sv
// Sequential single-MAC 2-D "same" convolution engine.
// One output pixel/channel at a time; one MAC per joint a/b handshake.
// Output order: y, x, co (inner). Tap order: ky, kx, ci (inner).
// Out-of-bounds taps are skipped without costing a cycle.
// Ports:
//   clk, rst_in            : clock, synchronous active-high reset
//   start / running        : start pulse (IDLE only) / busy flag
//   a_* / b_*              : activation / weight streams, joint handshake
//   out, output_valid      : saturated result and 1-cycle strobe
//   output_x/_y/_ch        : coordinates of the result
//   ext_mem_*              : write-back port; read side unused
// Build option OUT_WRITEBACK_EN: write the unsaturated accumulator to
// ext_mem at co + OC*(x + W*y) in the EMIT cycle; otherwise the write
// port is held at zero.
module top_chip_conv
   import top_chip_conv_pkg::*;
#(
   parameter int unsigned EXT_MEM_HEIGHT     = 1 << 20,
   parameter int unsigned FEATURE_MAP_WIDTH  = 1024,
   parameter int unsigned FEATURE_MAP_HEIGHT = 1024,
   parameter int unsigned INPUT_NB_CHANNELS  = 64,
   parameter int unsigned OUTPUT_NB_CHANNELS = 64,
   parameter int unsigned KERNEL_SIZE        = 3
) (
   input  logic                                    clk,
   input  logic                                    rst_in,
   output logic [cw(EXT_MEM_HEIGHT)-1:0]           ext_mem_read_addr,
   input  logic [ACCUMULATION_WIDTH-1:0]           ext_mem_qout,
   output logic [cw(EXT_MEM_HEIGHT)-1:0]           ext_mem_write_addr,
   output logic [ACCUMULATION_WIDTH-1:0]           ext_mem_din,
   output logic                                    ext_mem_write_en,
   input  logic signed [IO_DATA_WIDTH-1:0]         a_input,
   input  logic                                    a_valid,
   output logic                                    a_ready,
   input  logic signed [IO_DATA_WIDTH-1:0]         b_input,
   input  logic                                    b_valid,
   output logic                                    b_ready,
   output logic signed [IO_DATA_WIDTH-1:0]         out,
   output logic                                    output_valid,
   output logic [cw(FEATURE_MAP_WIDTH)-1:0]        output_x,
   output logic [cw(FEATURE_MAP_HEIGHT)-1:0]       output_y,
   output logic [cw(OUTPUT_NB_CHANNELS)-1:0]       output_ch,
   input  logic                                    start,
   output logic                                    running
);

   localparam int unsigned AW = cw(EXT_MEM_HEIGHT);
   localparam int unsigned XW = cw(FEATURE_MAP_WIDTH);
   localparam int unsigned YW = cw(FEATURE_MAP_HEIGHT);
   localparam int unsigned CW = cw(OUTPUT_NB_CHANNELS);
   localparam int unsigned IW = cw(INPUT_NB_CHANNELS);
   localparam int unsigned KK = KERNEL_SIZE * KERNEL_SIZE;
   localparam int unsigned TW = cw(KK);
   localparam int KI = int'(KERNEL_SIZE);
   localparam int WI = int'(FEATURE_MAP_WIDTH);
   localparam int HI = int'(FEATURE_MAP_HEIGHT);

   state_t                          state_q, state_d;
   logic [XW-1:0]                   x_q, x_d;
   logic [YW-1:0]                   y_q, y_d;
   logic [CW-1:0]                   co_q, co_d;
   logic [IW-1:0]                   ci_q, ci_d;
   logic [TW-1:0]                   tap_q, tap_d;
   logic signed [IO_DATA_WIDTH-1:0] out_q, out_d;
   logic                            ov_q, ov_d;
   logic [XW-1:0]                   ox_q, ox_d;
   logic [YW-1:0]                   oy_q, oy_d;
   logic [CW-1:0]                   och_q, och_d;
   logic                            running_q, running_d;

   logic                                 hs_c;
   logic                                 mac_clear;
   logic signed [ACCUMULATION_WIDTH-1:0] acc;
   logic signed [ACCUMULATION_WIDTH-1:0] acc_nxt_c;
   int                                   eff_tap;
   logic                                 more_taps;
   logic                                 last_out;
   logic                                 unused_qout;

`ifdef OUT_WRITEBACK_EN
   logic                          wr_en_q, wr_en_d;
   logic [AW-1:0]                 wr_addr_q, wr_addr_d;
   logic [ACCUMULATION_WIDTH-1:0] din_q, din_d;
`endif

   // Tap t = ky*K + kx lands inside the input map for output (x, y).
   function automatic logic tap_in(input int t, input int x, input int y);
      int ix;
      int iy;
      ix = x + (t % KI) - (KI / 2);
      iy = y + (t / KI) - (KI / 2);
      return (ix >= 0) && (ix < WI) && (iy >= 0) && (iy < HI);
   endfunction

   assign hs_c    = (state_q == FETCH) && a_valid && b_valid;
   assign a_ready = hs_c;
   assign b_ready = hs_c;

   conv_mac u_mac (
      .clk       (clk),
      .rst_in    (rst_in),
      .clear     (mac_clear),
      .en        (hs_c),
      .a         (a_input),
      .b         (b_input),
      .acc       (acc),
      .acc_nxt_c (acc_nxt_c)
   );

   // Current in-bounds tap at or after tap_q, and whether another follows.
   always_comb begin
      logic found;
      found     = 1'b0;
      eff_tap   = int'(tap_q);
      more_taps = 1'b0;
      for (int t = 0; t < int'(KK); t++) begin
         if (!found && (t >= int'(tap_q)) && tap_in(t, int'(x_q), int'(y_q))) begin
            eff_tap = t;
            found   = 1'b1;
         end
      end
      for (int t = 0; t < int'(KK); t++) begin
         if ((t > eff_tap) && tap_in(t, int'(x_q), int'(y_q))) begin
            more_taps = 1'b1;
         end
      end
   end

   assign last_out = (co_q == CW'(OUTPUT_NB_CHANNELS - 1)) &&
                     (x_q == XW'(FEATURE_MAP_WIDTH - 1)) &&
                     (y_q == YW'(FEATURE_MAP_HEIGHT - 1));

   // Next-state, counters and registered outputs.
   always_comb begin
      state_d   = state_q;
      x_d       = x_q;
      y_d       = y_q;
      co_d      = co_q;
      ci_d      = ci_q;
      tap_d     = tap_q;
      out_d     = out_q;
      ov_d      = 1'b0;
      ox_d      = ox_q;
      oy_d      = oy_q;
      och_d     = och_q;
      mac_clear = 1'b0;
`ifdef OUT_WRITEBACK_EN
      wr_en_d   = 1'b0;
      wr_addr_d = wr_addr_q;
      din_d     = din_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d   = FETCH;
               mac_clear = 1'b1;
            end
         end
         FETCH: begin
            tap_d = TW'(eff_tap);
            if (hs_c) begin
               if (ci_q == IW'(INPUT_NB_CHANNELS - 1)) begin
                  ci_d = '0;
                  if (more_taps) begin
                     tap_d = TW'(eff_tap + 1);
                  end else begin
                     // Last tap: result is visible the cycle we sit in EMIT.
                     tap_d   = '0;
                     state_d = EMIT;
                     ov_d    = 1'b1;
                     out_d   = sat16(acc_nxt_c);
                     ox_d    = x_q;
                     oy_d    = y_q;
                     och_d   = co_q;
`ifdef OUT_WRITEBACK_EN
                     wr_en_d   = 1'b1;
                     wr_addr_d = AW'(co_q) + AW'(OUTPUT_NB_CHANNELS) *
                                 (AW'(x_q) + AW'(FEATURE_MAP_WIDTH) * AW'(y_q));
                     din_d     = acc_nxt_c;
`endif
                  end
               end else begin
                  ci_d = ci_q + IW'(1);
               end
            end
         end
         EMIT: begin
            mac_clear = 1'b1;
            state_d   = last_out ? IDLE : FETCH;
            if (co_q == CW'(OUTPUT_NB_CHANNELS - 1)) begin
               co_d = '0;
               if (x_q == XW'(FEATURE_MAP_WIDTH - 1)) begin
                  x_d = '0;
                  y_d = (y_q == YW'(FEATURE_MAP_HEIGHT - 1)) ? '0 : y_q + YW'(1);
               end else begin
                  x_d = x_q + XW'(1);
               end
            end else begin
               co_d = co_q + CW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
      running_d = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst_in) begin
         state_q   <= IDLE;
         x_q       <= '0;
         y_q       <= '0;
         co_q      <= '0;
         ci_q      <= '0;
         tap_q     <= '0;
         out_q     <= '0;
         ov_q      <= 1'b0;
         ox_q      <= '0;
         oy_q      <= '0;
         och_q     <= '0;
         running_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         x_q       <= x_d;
         y_q       <= y_d;
         co_q      <= co_d;
         ci_q      <= ci_d;
         tap_q     <= tap_d;
         out_q     <= out_d;
         ov_q      <= ov_d;
         ox_q      <= ox_d;
         oy_q      <= oy_d;
         och_q     <= och_d;
         running_q <= running_d;
      end
   end

`ifdef OUT_WRITEBACK_EN
   always_ff @(posedge clk) begin
      if (rst_in) begin
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         din_q     <= '0;
      end else begin
         wr_en_q   <= wr_en_d;
         wr_addr_q <= wr_addr_d;
         din_q     <= din_d;
      end
   end

   assign ext_mem_write_en   = wr_en_q;
   assign ext_mem_write_addr = wr_addr_q;
   assign ext_mem_din        = din_q;
`else
   assign ext_mem_write_en   = 1'b0;
   assign ext_mem_write_addr = '0;
   assign ext_mem_din        = '0;
`endif

   assign ext_mem_read_addr = '0;
   assign unused_qout       = ^ext_mem_qout;

   assign out          = out_q;
   assign output_valid = ov_q;
   assign output_x     = ox_q;
   assign output_y     = oy_q;
   assign output_ch    = och_q;
   assign running      = running_q;

endmodule

// File: tb/tb_top_chip_conv.sv
// Directed bench for top_chip_conv: a 1x1/K=1 instance (u_dut1) and a
// 2x2/K=3 instance (u_dut2) sharing clock and reset.
module tb_top_chip_conv;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   task automatic check(input string tag, input longint got, input longint exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   // ---------------- instance 1: W=H=1, K=1, IC=OC=1 ----------------
   logic [19:0]        p1_raddr, p1_waddr;
   logic [31:0]        p1_din;
   logic               p1_wen;
   logic signed [15:0] p1_a = '0, p1_b = '0, p1_out;
   logic               p1_av = 1'b0, p1_bv = 1'b0, p1_ar, p1_br;
   logic               p1_ov, p1_start = 1'b0, p1_running;
   logic [0:0]         p1_x, p1_y, p1_ch;

   top_chip_conv #(
      .FEATURE_MAP_WIDTH(1), .FEATURE_MAP_HEIGHT(1),
      .INPUT_NB_CHANNELS(1), .OUTPUT_NB_CHANNELS(1), .KERNEL_SIZE(1)
   ) u_dut1 (
      .clk(clk), .rst_in(rst),
      .ext_mem_read_addr(p1_raddr), .ext_mem_qout(32'd0),
      .ext_mem_write_addr(p1_waddr), .ext_mem_din(p1_din), .ext_mem_write_en(p1_wen),
      .a_input(p1_a), .a_valid(p1_av), .a_ready(p1_ar),
      .b_input(p1_b), .b_valid(p1_bv), .b_ready(p1_br),
      .out(p1_out), .output_valid(p1_ov),
      .output_x(p1_x), .output_y(p1_y), .output_ch(p1_ch),
      .start(p1_start), .running(p1_running)
   );

   // ---------------- instance 2: W=H=2, K=3, IC=OC=1 ----------------
   logic [19:0]        p2_raddr, p2_waddr;
   logic [31:0]        p2_din;
   logic               p2_wen;
   logic signed [15:0] p2_a = '0, p2_b = '0, p2_out;
   logic               p2_av = 1'b0, p2_bv = 1'b0, p2_ar, p2_br;
   logic               p2_ov, p2_start = 1'b0, p2_running;
   logic [0:0]         p2_x, p2_y, p2_ch;

   top_chip_conv #(
      .FEATURE_MAP_WIDTH(2), .FEATURE_MAP_HEIGHT(2),
      .INPUT_NB_CHANNELS(1), .OUTPUT_NB_CHANNELS(1), .KERNEL_SIZE(3)
   ) u_dut2 (
      .clk(clk), .rst_in(rst),
      .ext_mem_read_addr(p2_raddr), .ext_mem_qout(32'd0),
      .ext_mem_write_addr(p2_waddr), .ext_mem_din(p2_din), .ext_mem_write_en(p2_wen),
      .a_input(p2_a), .a_valid(p2_av), .a_ready(p2_ar),
      .b_input(p2_b), .b_valid(p2_bv), .b_ready(p2_br),
      .out(p2_out), .output_valid(p2_ov),
      .output_x(p2_x), .output_y(p2_y), .output_ch(p2_ch),
      .start(p2_start), .running(p2_running)
   );

   // Handshake counters (joint handshake, so a_ready is enough).
   int hs1 = 0;
   int hs2 = 0;
   always @(posedge clk) begin
      if (!rst && p1_ar) hs1++;
      if (!rst && p2_ar) hs2++;
   end

`ifdef OUT_WRITEBACK_EN
   localparam bit WB = 1'b1;
`else
   localparam bit WB = 1'b0;
`endif

   task automatic run1(input logic signed [15:0] a, input logic signed [15:0] b,
                       input longint exp_out, input longint exp_full);
      int hs0;
      int cyc;
      hs0 = hs1;
      @(negedge clk);
      p1_a = a; p1_b = b; p1_av = 1'b1; p1_bv = 1'b1; p1_start = 1'b1;
      @(negedge clk);
      p1_start = 1'b0;
      check("p1_running_rise", p1_running, 1);
      cyc = 0;
      while (!p1_ov && cyc < 20) begin
         @(negedge clk);
         cyc++;
      end
      check("p1_ov_seen", p1_ov, 1);
      check("p1_latency", cyc, 1);
      check("p1_out", p1_out, exp_out);
      check("p1_x", p1_x, 0);
      check("p1_y", p1_y, 0);
      check("p1_ch", p1_ch, 0);
      check("p1_wen", p1_wen, WB ? 1 : 0);
      check("p1_waddr", p1_waddr, 0);
      check("p1_din", p1_din, WB ? exp_full : 0);
      check("p1_hs", hs1 - hs0, 1);
      p1_av = 1'b0; p1_bv = 1'b0;
      @(negedge clk);
      check("p1_running_fall", p1_running, 0);
      check("p1_ov_low", p1_ov, 0);
      check("p1_out_hold", p1_out, exp_out);
   endtask

   // Full 2x2 run with a=b=1; optional backpressure and stray start pulse.
   task automatic run2(input bit bp, input bit pulse);
      int hs0;
      int n;
      bit bp_done;
      hs0 = hs2; n = 0; bp_done = 1'b0;
      @(negedge clk);
      p2_a = 16'sd1; p2_b = 16'sd1; p2_av = 1'b1; p2_bv = 1'b1; p2_start = 1'b1;
      @(negedge clk);
      p2_start = 1'b0;
      for (int cyc = 0; cyc < 300; cyc++) begin
         if (p2_ov) begin
            if (n < 4) begin
               check("p2_out", p2_out, 4);
               check("p2_x", p2_x, n % 2);
               check("p2_y", p2_y, n / 2);
               check("p2_waddr", p2_waddr, WB ? n : 0);
               check("p2_din", p2_din, WB ? 4 : 0);
            end
            n++;
         end
         if (!p2_running) break;
         if (bp && !bp_done && (hs2 - hs0 == 2)) begin
            p2_av = 1'b0;
            for (int k = 0; k < 5; k++) begin
               @(negedge clk);
               check("p2_bp_a_ready", p2_ar, 0);
               check("p2_bp_b_ready", p2_br, 0);
            end
            check("p2_bp_hs_held", hs2 - hs0, 2);
            p2_av = 1'b1;
            bp_done = 1'b1;
         end
         p2_start = (pulse && cyc == 5);
         @(negedge clk);
      end
      p2_start = 1'b0;
      check("p2_done", p2_running, 0);
      check("p2_n_out", n, 4);
      check("p2_hs", hs2 - hs0, 16);
      p2_av = 1'b0; p2_bv = 1'b0;
   endtask

   initial begin
      int hs0;
      int cyc;
      repeat (3) @(negedge clk);
      check("rst_running", p1_running, 0);
      check("rst_ov", p1_ov, 0);
      check("rst_out", p1_out, 0);
      check("rst_p2_running", p2_running, 0);
      rst = 1'b0;
      @(negedge clk);

      run1(16'sd3, -16'sd2, -6, -6);
      run1(16'sd32767, 16'sd32767, 32767, 1073676289);

      run2(1'b0, 1'b1);

      // Abort a run with reset during FETCH.
      hs0 = hs2;
      @(negedge clk);
      p2_a = 16'sd1; p2_b = 16'sd1; p2_av = 1'b1; p2_bv = 1'b1; p2_start = 1'b1;
      @(negedge clk);
      p2_start = 1'b0;
      cyc = 0;
      while ((hs2 - hs0) < 1 && cyc < 20) begin
         @(negedge clk);
         cyc++;
      end
      check("abort_in_fetch", p2_running, 1);
      rst = 1'b1;
      @(negedge clk);
      check("abort_running", p2_running, 0);
      check("abort_ov", p2_ov, 0);
      rst = 1'b0; p2_av = 1'b0; p2_bv = 1'b0;
      @(negedge clk);

      run2(1'b1, 1'b0);

      repeat (2) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
